// File: rtl/decoder_4to16_buf.sv
// decoder_4to16_buf: FIFO-buffered 4-to-16 one-hot decoder with valid/ready ports and transfer counter
module decoder_4to16_buf #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_code,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [15:0]      out_onehot,
  output logic [3:0]       out_code,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0]       mem_q [DEPTH];
  logic [3:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;
  logic [3:0]       head;
  assign in_ready   = count_q != (AW+1)'(DEPTH);
  assign out_valid  = count_q != '0;
  assign head       = mem_q[rd_ptr_q];
  assign out_code   = out_valid ? head : 4'h0;
  assign out_onehot = out_valid ? 16'(1) << head : 16'h0000;
  assign xfer_cnt   = xfer_cnt_q;
  assign overflow   = overflow_q;
  // Next-state: handshakes, pointer advance (power-of-two wrap), occupancy and debug counters
  always_comb begin
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = in_code;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    xfer_cnt_d = xfer_cnt_q + CNT_W'(pop);
    overflow_d = overflow_q | (in_valid & ~in_ready);
  end
  // State registers; async reset discards all buffered entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      xfer_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      xfer_cnt_q <= xfer_cnt_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_decoder_4to16_buf.sv
// tb_decoder_4to16_buf: scoreboard-driven directed bench for the buffered 4-to-16 decoder
module tb_decoder_4to16_buf;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_code = 4'h0;
  logic        in_ready;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_onehot;
  logic [3:0]  out_code;
  logic [7:0]  xfer_cnt;
  logic        overflow;
  logic [3:0]  sb [$];
  logic [7:0]  exp_xfer = 8'd0;
  logic        exp_ovf = 1'b0;
  int          errors = 0;
  int          checks = 0;

  decoder_4to16_buf #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_onehot(out_onehot), .out_code(out_code),
    .xfer_cnt(xfer_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_onehot"}, out_onehot, 16'h0000);
    chk({tag, "_code"}, out_code, 4'h0);
    chk({tag, "_xfer"}, xfer_cnt, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic do_reset();
    sb.delete();
    exp_xfer = 8'd0;
    exp_ovf = 1'b0;
  endtask

  task automatic cycle();
    logic do_push, do_pop, do_ovf;
    logic [15:0] e_oh;
    logic [3:0]  e_code;
    @(negedge clk);
    e_code = sb.size() != 0 ? sb[0] : 4'h0;
    e_oh   = sb.size() != 0 ? 16'(1) << sb[0] : 16'h0000;
    chk("in_ready", in_ready, sb.size() != DEPTH);
    chk("out_valid", out_valid, sb.size() != 0);
    chk("out_onehot", out_onehot, e_oh);
    chk("out_code", out_code, e_code);
    chk("xfer_cnt", xfer_cnt, exp_xfer);
    chk("overflow", overflow, exp_ovf);
    do_push = in_valid && sb.size() != DEPTH;
    do_pop  = out_ready && sb.size() != 0;
    do_ovf  = in_valid && sb.size() == DEPTH;
    @(posedge clk);
    if (do_pop) begin
      void'(sb.pop_front());
      exp_xfer++;
    end
    if (do_push) sb.push_back(in_code);
    if (do_ovf) exp_ovf = 1'b1;
    #1;
  endtask

  initial begin
    logic hit;
    // reset held with in_valid=1: nothing may be pushed
    in_valid = 1'b1;
    in_code = 4'h7;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst_init");
    in_valid = 1'b0;
    rst_n = 1'b1;
    // exhaustive decode 0..15 with consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_code = 4'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("xfer_after_16", xfer_cnt, 16);
    // fill to full with consumer stalled
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_code = 4'h3;
    cycle();
    in_code = 4'hA;
    cycle();
    chk("full_in_ready", in_ready, 0);
    chk("full_onehot", out_onehot, 16'h0008);
    in_code = 4'hF;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("ovf_set", overflow, 1);
    chk("held_onehot", out_onehot, 16'h0008);
    // drain in order
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("drained_valid", out_valid, 0);
    chk("drained_onehot", out_onehot, 16'h0000);
    // simultaneous push/pop at count=1
    in_valid = 1'b1;
    in_code = 4'h5;
    for (int i = 0; i < 20; i++) begin
      in_code = 4'(5 + i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();
    // stream until the transfer counter wraps to 0
    in_valid = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 600 && !hit; k++) begin
      in_code = 4'($urandom_range(0, 15));
      cycle();
      hit = exp_xfer == 8'd0;
    end
    chk("xfer_wrap", xfer_cnt, 0);
    // fill two entries then async reset mid-cycle with in_valid high
    out_ready = 1'b0;
    in_code = 4'hC;
    repeat (2) cycle();
    chk("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    do_reset();
    chk_reset_state("rst_async");
    @(posedge clk);
    #1;
    chk_reset_state("rst_hold");
    rst_n = 1'b1;
    in_code = 4'h9;
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle();
    chk("post_rst_xfer", xfer_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
